decode: RTL and testbench
=========================

DECODE -- requirements
Module: decode

Interface
REQ-001 Clock and reset SHALL be: reset reset, synchronous, active-high; clock clk.
REQ-002 Parameters: none.
REQ-003 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- stall  in  1  hazard: hold output register
- invalidate  in  1  hazard: load bubble
- pc_in / next_pc_in  in  32 each  from fetch
- instruction_in  in  32  from fetch
- valid_in  in  1  from fetch
- pc_out / next_pc_out  out  32 each  to execute
- rs1_addr_out / rs2_addr_out / rd_addr_out  out  5 each  instruction[19:15] / [24:20] / [11:7]
- uses_rs1_out / uses_rs2_out  out  1 each  operand read needed (hazard detection)
- imm_out  out  32  decoded immediate
- alu_op_out  out  4  ALU function
- alu_a_sel_out  out  1  0=rs1, 1=pc
- alu_b_sel_out  out  1  0=rs2, 1=imm
- funct3_out  out  3  instruction[14:12]
- rd_write_out  out  1  register write enable
- wb_sel_out  out  2  0=ALU, 1=memory, 2=next_pc, 3=CSR
- jump_out / branch_out / load_out / store_out / csr_out  out  1 each  class flags
- ecall_out / ebreak_out / mret_out / illegal_out  out  1 each  system/trap flags
- valid_out  out  1  output holds a real instruction

Function
REQ-004 All outputs SHALL be registered; latency exactly one cycle from inputs to outputs.
REQ-005 Update priority SHALL be reset > stall > invalidate > load.
REQ-006 stall=1: every output holds its value, including when invalidate=1.
REQ-007 Bubble (stall=0 and (invalidate=1 or valid_in=0)): valid_out=0 and every other output loaded with 0.
REQ-008 Load (stall=0, invalidate=0, valid_in=1): valid_out=1, all fields decoded from instruction_in; pc/next_pc passed through.
REQ-009 Immediates SHALL be sign-extended from bit 31: I for OP-IMM/LOAD/JALR, S for STORE, B for BRANCH, J for JAL, U (imm[31:12], low 12 bits 0) for LUI/AUIPC; SYSTEM: {20'b0, instruction[31:20]}; otherwise 0.
REQ-010 alu_op encoding: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B; SUB only for OP funct7=0100000, SRA for funct7=0100000 shifts.
REQ-011 Per class: LUI PASS_B, b=imm, wb 0; AUIPC a=pc, b=imm, ADD; JAL a=pc, b=imm, ADD, jump, wb 2; JALR a=rs1, b=imm, ADD, jump, wb 2; BRANCH a=pc, b=imm, ADD, branch; LOAD/STORE a=rs1, b=imm, ADD, wb 1 for load; CSR wb 3.
REQ-012 uses_rs1=1 for JALR, BRANCH, LOAD, STORE, OP, OP-IMM, CSR with funct3[2]=0; uses_rs2=1 for BRANCH, STORE, OP.
REQ-013 rd_write=1 only for LUI, AUIPC, JAL, JALR, LOAD, OP, OP-IMM, CSR, and only when rd_addr!=0.
REQ-014 Illegal: instruction[1:0]!=11; unknown opcode; JALR funct3!=0; BRANCH funct3 010/011; LOAD funct3 not in {000,001,010,100,101}; STORE funct3>010; bad funct7 on OP/shift-immediate; SYSTEM other than 0x00000073 (ecall), 0x00100073 (ebreak), 0x30200073 (mret), CSR funct3 not in {000,100}.
REQ-015 Illegal instruction: valid_out=1, illegal_out=1, rd_write/jump/branch/load/store/csr/ecall/ebreak/mret=0.
REQ-016 FENCE (0001111) SHALL decode as legal no-op: all flags 0, valid_out=1.

Reset
REQ-017 reset=1 at clock edge: all outputs 0 next cycle, regardless of stall/invalidate, including mid-stall.

Verification
REQ-018 0x00500093 (addi x1,x0,5), valid_in=1 -> rd=1, rs1=0, imm=0x00000005, alu_op=0, b_sel=1, rd_write=1, uses_rs1=1, valid_out=1.
REQ-019 0xFE20AE23 (sw x2,-4(x1)) -> store=1, imm=0xFFFFFFFC, rs1=1, rs2=2, funct3=010, rd_write=0, uses_rs2=1.
REQ-020 0x0000006F (jal x0,0) -> jump=1, wb_sel=2, a_sel=1, imm=0, rd_write=0.
REQ-021 0x00000000 -> illegal=1, valid_out=1, all class flags 0; 0x30200073 -> mret=1, illegal=0.
REQ-022 Load addi, then stall=1 with invalidate=1 for 3 cycles -> outputs unchanged; stall=0, invalidate=1 -> valid_out=0, all outputs 0.
REQ-023 reset asserted while stall=1 and valid_out=1 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/decode.sv
// Instruction decode stage: turns a fetched RV32I word into execute-stage control fields.
// Latency: one cycle, every output comes straight from a register.
// Backpressure: stall freezes the output register; invalidate or valid_in=0 loads an all-zero bubble.
module decode (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        invalidate,
    input  logic [31:0] pc_in,
    input  logic [31:0] next_pc_in,
    input  logic [31:0] instruction_in,
    input  logic        valid_in,
    output logic [31:0] pc_out,
    output logic [31:0] next_pc_out,
    output logic [4:0]  rs1_addr_out,
    output logic [4:0]  rs2_addr_out,
    output logic [4:0]  rd_addr_out,
    output logic        uses_rs1_out,
    output logic        uses_rs2_out,
    output logic [31:0] imm_out,
    output logic [3:0]  alu_op_out,
    output logic        alu_a_sel_out,
    output logic        alu_b_sel_out,
    output logic [2:0]  funct3_out,
    output logic        rd_write_out,
    output logic [1:0]  wb_sel_out,
    output logic        jump_out,
    output logic        branch_out,
    output logic        load_out,
    output logic        store_out,
    output logic        csr_out,
    output logic        ecall_out,
    output logic        ebreak_out,
    output logic        mret_out,
    output logic        illegal_out,
    output logic        valid_out
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;

    localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSN_MRET   = 32'h3020_0073;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic        uses_rs1;
        logic        uses_rs2;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic        alu_a_sel;
        logic        alu_b_sel;
        logic [2:0]  funct3;
        logic        rd_write;
        logic [1:0]  wb_sel;
        logic        jump;
        logic        branch;
        logic        load;
        logic        store;
        logic        csr;
        logic        ecall;
        logic        ebreak;
        logic        mret;
        logic        illegal;
        logic        valid;
    } dec_t;

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [31:0] insn;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;

    assign insn   = instruction_in;
    assign opcode = insn[6:0];
    assign f3     = insn[14:12];
    assign f7     = insn[31:25];
    assign imm_i  = {{20{insn[31]}}, insn[31:20]};
    assign imm_s  = {{20{insn[31]}}, insn[31:25], insn[11:7]};
    assign imm_b  = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    assign imm_j  = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
    assign imm_u  = {insn[31:12], 12'b0};

    dec_t dec_new;
    dec_t dec_d;
    dec_t dec_q;
    logic ill;
    logic wr;

    // Decode the incoming word into a full set of control fields
    always_comb begin
        dec_new = '0;
        ill     = 1'b0;
        wr      = 1'b0;
        dec_new.pc       = pc_in;
        dec_new.next_pc  = next_pc_in;
        dec_new.rs1_addr = insn[19:15];
        dec_new.rs2_addr = insn[24:20];
        dec_new.rd_addr  = insn[11:7];
        dec_new.funct3   = f3;
        dec_new.valid    = 1'b1;
        if (insn[1:0] != 2'b11) begin
            ill = 1'b1;
        end else begin
            case (opcode)
                OPC_LUI: begin
                    dec_new.imm       = imm_u;
                    dec_new.alu_op    = ALU_PASS_B;
                    dec_new.alu_b_sel = 1'b1;
                    wr = 1'b1;
                end
                OPC_AUIPC: begin
                    dec_new.imm       = imm_u;
                    dec_new.alu_a_sel = 1'b1;
                    dec_new.alu_b_sel = 1'b1;
                    wr = 1'b1;
                end
                OPC_JAL: begin
                    dec_new.imm       = imm_j;
                    dec_new.alu_a_sel = 1'b1;
                    dec_new.alu_b_sel = 1'b1;
                    dec_new.jump      = 1'b1;
                    dec_new.wb_sel    = 2'd2;
                    wr = 1'b1;
                end
                OPC_JALR: begin
                    dec_new.imm       = imm_i;
                    dec_new.alu_b_sel = 1'b1;
                    dec_new.jump      = 1'b1;
                    dec_new.wb_sel    = 2'd2;
                    dec_new.uses_rs1  = 1'b1;
                    wr  = 1'b1;
                    ill = (f3 != 3'b000);
                end
                OPC_BRANCH: begin
                    dec_new.imm       = imm_b;
                    dec_new.alu_a_sel = 1'b1;
                    dec_new.alu_b_sel = 1'b1;
                    dec_new.branch    = 1'b1;
                    dec_new.uses_rs1  = 1'b1;
                    dec_new.uses_rs2  = 1'b1;
                    ill = (f3 == 3'b010) || (f3 == 3'b011);
                end
                OPC_LOAD: begin
                    dec_new.imm       = imm_i;
                    dec_new.alu_b_sel = 1'b1;
                    dec_new.load      = 1'b1;
                    dec_new.wb_sel    = 2'd1;
                    dec_new.uses_rs1  = 1'b1;
                    wr  = 1'b1;
                    ill = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
                end
                OPC_STORE: begin
                    dec_new.imm       = imm_s;
                    dec_new.alu_b_sel = 1'b1;
                    dec_new.store     = 1'b1;
                    dec_new.uses_rs1  = 1'b1;
                    dec_new.uses_rs2  = 1'b1;
                    ill = (f3 > 3'b010);
                end
                OPC_OPIMM: begin
                    dec_new.imm       = imm_i;
                    dec_new.alu_b_sel = 1'b1;
                    dec_new.alu_op    = alu_of(f3, (f3 == 3'b101) && f7[5]);
                    dec_new.uses_rs1  = 1'b1;
                    wr  = 1'b1;
                    ill = ((f3 == 3'b001) && (f7 != F7_ZERO)) ||
                          ((f3 == 3'b101) && (f7 != F7_ZERO) && (f7 != F7_ALT));
                end
                OPC_OP: begin
                    dec_new.alu_op   = alu_of(f3, f7[5]);
                    dec_new.uses_rs1 = 1'b1;
                    dec_new.uses_rs2 = 1'b1;
                    wr  = 1'b1;
                    ill = !((f7 == F7_ZERO) ||
                            ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
                end
                OPC_FENCE: begin
                    // legal no-op: nothing beyond the default fields
                end
                OPC_SYSTEM: begin
                    dec_new.imm = {20'b0, insn[31:20]};
                    if (f3 == 3'b000) begin
                        if (insn == INSN_ECALL)       dec_new.ecall  = 1'b1;
                        else if (insn == INSN_EBREAK) dec_new.ebreak = 1'b1;
                        else if (insn == INSN_MRET)   dec_new.mret   = 1'b1;
                        else                          ill = 1'b1;
                    end else if (f3 == 3'b100) begin
                        ill = 1'b1;
                    end else begin
                        // CSR ops; funct3[2] set means the rs1 field is a zimm
                        dec_new.csr      = 1'b1;
                        dec_new.wb_sel   = 2'd3;
                        dec_new.uses_rs1 = !f3[2];
                        wr = 1'b1;
                    end
                end
                default: ill = 1'b1;
            endcase
        end
        dec_new.rd_write = wr && (insn[11:7] != 5'd0);
        if (ill) begin
            // keep only the raw fields so nothing downstream acts on the word
            dec_new          = '0;
            dec_new.pc       = pc_in;
            dec_new.next_pc  = next_pc_in;
            dec_new.rs1_addr = insn[19:15];
            dec_new.rs2_addr = insn[24:20];
            dec_new.rd_addr  = insn[11:7];
            dec_new.funct3   = f3;
            dec_new.valid    = 1'b1;
            dec_new.illegal  = 1'b1;
        end
    end

    // Choose hold, bubble or load for the output register
    always_comb begin
        dec_d = dec_q;
        if (!stall) begin
            if (invalidate || !valid_in) dec_d = '0;
            else                         dec_d = dec_new;
        end
    end

    // Output register with synchronous reset taking priority over stall
    always_ff @(posedge clk) begin
        if (reset) dec_q <= '0;
        else       dec_q <= dec_d;
    end

    assign pc_out        = dec_q.pc;
    assign next_pc_out   = dec_q.next_pc;
    assign rs1_addr_out  = dec_q.rs1_addr;
    assign rs2_addr_out  = dec_q.rs2_addr;
    assign rd_addr_out   = dec_q.rd_addr;
    assign uses_rs1_out  = dec_q.uses_rs1;
    assign uses_rs2_out  = dec_q.uses_rs2;
    assign imm_out       = dec_q.imm;
    assign alu_op_out    = dec_q.alu_op;
    assign alu_a_sel_out = dec_q.alu_a_sel;
    assign alu_b_sel_out = dec_q.alu_b_sel;
    assign funct3_out    = dec_q.funct3;
    assign rd_write_out  = dec_q.rd_write;
    assign wb_sel_out    = dec_q.wb_sel;
    assign jump_out      = dec_q.jump;
    assign branch_out    = dec_q.branch;
    assign load_out      = dec_q.load;
    assign store_out     = dec_q.store;
    assign csr_out       = dec_q.csr;
    assign ecall_out     = dec_q.ecall;
    assign ebreak_out    = dec_q.ebreak;
    assign mret_out      = dec_q.mret;
    assign illegal_out   = dec_q.illegal;
    assign valid_out     = dec_q.valid;

endmodule

// File: tb/tb_decode.sv
// Directed bench for the decode stage: hand-encoded RV32I words with hand-computed fields.
// Latency: each step drives inputs, waits one rising edge, samples 1 time unit later.
// Backpressure: stall/invalidate/reset priority exercised with explicit sequences.
module tb_decode;

    logic        clk = 1'b0;
    logic        reset, stall, invalidate, valid_in;
    logic [31:0] pc_in, next_pc_in, instruction_in;
    logic [31:0] pc_out, next_pc_out, imm_out;
    logic [4:0]  rs1_addr_out, rs2_addr_out, rd_addr_out;
    logic        uses_rs1_out, uses_rs2_out, alu_a_sel_out, alu_b_sel_out, rd_write_out;
    logic [3:0]  alu_op_out;
    logic [2:0]  funct3_out;
    logic [1:0]  wb_sel_out;
    logic        jump_out, branch_out, load_out, store_out, csr_out;
    logic        ecall_out, ebreak_out, mret_out, illegal_out, valid_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decode dut (
        .clk(clk), .reset(reset), .stall(stall), .invalidate(invalidate),
        .pc_in(pc_in), .next_pc_in(next_pc_in), .instruction_in(instruction_in),
        .valid_in(valid_in),
        .pc_out(pc_out), .next_pc_out(next_pc_out),
        .rs1_addr_out(rs1_addr_out), .rs2_addr_out(rs2_addr_out), .rd_addr_out(rd_addr_out),
        .uses_rs1_out(uses_rs1_out), .uses_rs2_out(uses_rs2_out),
        .imm_out(imm_out), .alu_op_out(alu_op_out),
        .alu_a_sel_out(alu_a_sel_out), .alu_b_sel_out(alu_b_sel_out),
        .funct3_out(funct3_out), .rd_write_out(rd_write_out), .wb_sel_out(wb_sel_out),
        .jump_out(jump_out), .branch_out(branch_out), .load_out(load_out),
        .store_out(store_out), .csr_out(csr_out),
        .ecall_out(ecall_out), .ebreak_out(ebreak_out), .mret_out(mret_out),
        .illegal_out(illegal_out), .valid_out(valid_out)
    );

    // every output concatenated, for all-zero checks
    logic [134:0] all_out;
    assign all_out = {pc_out, next_pc_out, rs1_addr_out, rs2_addr_out, rd_addr_out,
                      uses_rs1_out, uses_rs2_out, imm_out, alu_op_out, alu_a_sel_out,
                      alu_b_sel_out, funct3_out, rd_write_out, wb_sel_out, jump_out,
                      branch_out, load_out, store_out, csr_out, ecall_out, ebreak_out,
                      mret_out, illegal_out, valid_out};

    // the nine flags that an illegal word must leave clear
    logic [8:0] side_flags;
    assign side_flags = {rd_write_out, jump_out, branch_out, load_out, store_out,
                         csr_out, ecall_out, ebreak_out, mret_out};

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic stl, input logic inv, input logic vld,
                        input logic [31:0] insn, input logic [31:0] pc);
        reset          = rst;
        stall          = stl;
        invalidate     = inv;
        valid_in       = vld;
        instruction_in = insn;
        pc_in          = pc;
        next_pc_in     = pc + 32'd4;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; invalidate = 1'b0; valid_in = 1'b0;
        pc_in = '0; next_pc_in = '0; instruction_in = '0;

        // reset state
        step(1, 0, 0, 1, 32'h00500093, 32'h10);
        chk("reset_all_zero", all_out, 0);

        // addi x1,x0,5
        step(0, 0, 0, 1, 32'h00500093, 32'h100);
        chk("addi_rd",      rd_addr_out, 1);
        chk("addi_rs1",     rs1_addr_out, 0);
        chk("addi_imm",     imm_out, 32'h5);
        chk("addi_alu",     {alu_op_out, alu_a_sel_out, alu_b_sel_out}, {4'd0, 1'b0, 1'b1});
        chk("addi_ctl",     {rd_write_out, uses_rs1_out, uses_rs2_out, wb_sel_out, valid_out, illegal_out},
                            {1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0});
        chk("addi_pc",      {pc_out, next_pc_out}, {32'h100, 32'h104});

        // sw x2,-4(x1)
        step(0, 0, 0, 1, 32'hFE20AE23, 32'h104);
        chk("sw_imm",       imm_out, 32'hFFFFFFFC);
        chk("sw_regs",      {rs1_addr_out, rs2_addr_out, funct3_out}, {5'd1, 5'd2, 3'b010});
        chk("sw_ctl",       {store_out, load_out, rd_write_out, uses_rs1_out, uses_rs2_out, alu_b_sel_out, alu_op_out},
                            {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0});

        // jal x0,0
        step(0, 0, 0, 1, 32'h0000006F, 32'h108);
        chk("jal_ctl",      {jump_out, wb_sel_out, alu_a_sel_out, alu_b_sel_out, rd_write_out, alu_op_out},
                            {1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 4'd0});
        chk("jal_imm",      imm_out, 0);

        // all-zero word is illegal
        step(0, 0, 0, 1, 32'h00000000, 32'h10C);
        chk("zero_illegal", {valid_out, illegal_out}, 2'b11);
        chk("zero_flags",   side_flags, 0);

        // mret
        step(0, 0, 0, 1, 32'h30200073, 32'h110);
        chk("mret",         {mret_out, illegal_out, valid_out, csr_out, ecall_out}, {1'b1, 1'b0, 1'b1, 1'b0, 1'b0});

        // ecall
        step(0, 0, 0, 1, 32'h00000073, 32'h114);
        chk("ecall",        {ecall_out, ebreak_out, mret_out, illegal_out}, 4'b1000);

        // sub x3,x1,x2
        step(0, 0, 0, 1, 32'h402081B3, 32'h118);
        chk("sub",          {alu_op_out, rd_addr_out, rd_write_out, uses_rs2_out, alu_b_sel_out},
                            {4'd1, 5'd3, 1'b1, 1'b1, 1'b0});

        // srai x5,x6,3
        step(0, 0, 0, 1, 32'h40335293, 32'h11C);
        chk("srai",         {alu_op_out, imm_out, illegal_out, uses_rs2_out}, {4'd7, 32'h403, 1'b0, 1'b0});

        // lw x4,8(x2)
        step(0, 0, 0, 1, 32'h00812203, 32'h120);
        chk("lw",           {load_out, wb_sel_out, rd_write_out, imm_out, rs1_addr_out},
                            {1'b1, 2'd1, 1'b1, 32'h8, 5'd2});

        // beq x1,x2,-8
        step(0, 0, 0, 1, 32'hFE208CE3, 32'h124);
        chk("beq",          {branch_out, alu_a_sel_out, alu_b_sel_out, rd_write_out, imm_out},
                            {1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFFFFF8});

        // lui x7,0x12345
        step(0, 0, 0, 1, 32'h123453B7, 32'h128);
        chk("lui",          {imm_out, alu_op_out, alu_b_sel_out, rd_write_out, wb_sel_out, uses_rs1_out},
                            {32'h12345000, 4'd10, 1'b1, 1'b1, 2'd0, 1'b0});

        // csrrw x1,0x300,x2
        step(0, 0, 0, 1, 32'h300110F3, 32'h12C);
        chk("csrrw",        {csr_out, wb_sel_out, rd_write_out, uses_rs1_out, imm_out},
                            {1'b1, 2'd3, 1'b1, 1'b1, 32'h300});

        // jalr with funct3=001 is illegal
        step(0, 0, 0, 1, 32'h00009067, 32'h130);
        chk("jalr_bad_f3",  {illegal_out, valid_out, jump_out, side_flags}, {1'b1, 1'b1, 1'b0, 9'd0});

        // fence is a legal no-op
        step(0, 0, 0, 1, 32'h0FF0000F, 32'h134);
        chk("fence",        {valid_out, illegal_out, side_flags}, {1'b1, 1'b0, 9'd0});

        // valid_in=0 gives a bubble
        step(0, 0, 0, 0, 32'h00500093, 32'h138);
        chk("bubble_novalid", all_out, 0);

        // stall+invalidate holds the addi for three cycles, then invalidate bubbles
        step(0, 0, 0, 1, 32'h00500093, 32'h200);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 1, 32'hFE20AE23, 32'h300);
            chk("stall_hold", {valid_out, rd_write_out, rd_addr_out, imm_out, pc_out, store_out},
                              {1'b1, 1'b1, 5'd1, 32'h5, 32'h200, 1'b0});
        end
        step(0, 0, 1, 1, 32'hFE20AE23, 32'h300);
        chk("invalidate_bubble", all_out, 0);

        // reset during a stall clears everything
        step(0, 0, 0, 1, 32'h00500093, 32'h400);
        step(0, 1, 0, 1, 32'h00500093, 32'h404);
        chk("pre_reset_valid", valid_out, 1);
        step(1, 1, 0, 1, 32'h00500093, 32'h408);
        chk("reset_mid_stall", all_out, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
